// File: rtl/btb_pkg.sv
// Shared types for the BTB execute-side resolve path: 2-bit predictor states,
// the buffered fetch-time prediction record and BTB geometry constants.
package btb_pkg;

  localparam int unsigned BTB_INDEX_BITS = 3;
  localparam int unsigned BTB_TAG_BITS   = 27;
  // Tag + index + word-offset bits span the widest PC the prediction buffer holds.
  localparam int unsigned BTB_PC_BITS    = BTB_TAG_BITS + BTB_INDEX_BITS + 2;

  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } btb_fsm_t;

  typedef struct packed {
    logic [BTB_PC_BITS-1:0] pc;
    logic                   hit;
    logic [BTB_PC_BITS-1:0] target;
    logic                   taken;
    btb_fsm_t               fsm;
  } pred_entry_t;

  function automatic btb_fsm_t fsm_step(input btb_fsm_t s, input logic taken);
    case (s)
      STRONG_NT: return taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   return taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    return taken ? STRONG_T : WEAK_NT;
      default:   return taken ? STRONG_T : WEAK_T;
    endcase
  endfunction

endpackage

// File: rtl/btb_resolve_unit_pred_fifo.sv
// In-order buffer of fetch-time predictions (module pred_fifo).
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module pred_fifo
  import btb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  pred_entry_t push_data,
  output pred_entry_t head,
  output logic        full,
  output logic        empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  pred_entry_t     mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/btb_resolve_unit.sv
// Resolves buffered BTB predictions against EX outcomes; drives BTB write-back,
// mispredict/redirect and flush. Optional counters: define BTB_RESOLVE_STATS_EN.
module btb_resolve_unit
  import btb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            fetch_valid,
  input  logic [XLEN-1:0] fetch_pc,
  input  logic            pred_hit,
  input  logic [XLEN-1:0] pred_target,
  input  logic            pred_taken,
  input  logic [1:0]      pred_fsm,
  output logic            fetch_ready,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res_pc,
  input  logic            res_is_branch,
  input  logic            res_taken,
  input  logic [XLEN-1:0] res_target,
  output logic            res_ready,
  output logic            update,
  output logic [XLEN-1:0] updatePC,
  output logic [XLEN-1:0] updateTarget,
  output logic [1:0]      update_fsm,
  output logic            mispredicted,
  output logic [XLEN-1:0] redirect_pc,
  output logic            desync
`ifdef BTB_RESOLVE_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  pred_entry_t     in_entry;
  pred_entry_t     head;
  logic            full;
  logic            empty;
  logic            pop;
  logic            flush;
  logic [XLEN-1:0] head_pc;
  logic [XLEN-1:0] head_target;
  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] nxt_redirect;
  logic [XLEN-1:0] nxt_target;
  logic            nxt_update;
  logic            nxt_mis;
  btb_fsm_t        nxt_fsm;

  // Buffer entries are BTB_PC_BITS wide; XLEN is expected not to exceed it.
  always_comb begin
    in_entry        = '0;
    in_entry.pc     = BTB_PC_BITS'(fetch_pc);
    in_entry.hit    = pred_hit;
    in_entry.target = BTB_PC_BITS'(pred_target);
    in_entry.taken  = pred_taken;
    in_entry.fsm    = btb_fsm_t'(pred_fsm);
  end

  assign head_pc     = XLEN'(head.pc);
  assign head_target = XLEN'(head.target);
  assign fetch_ready = ~full;
  assign res_ready   = ~empty;
  assign pop         = res_valid & ~empty;
  assign flush       = pop & nxt_mis;

  pred_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fetch_valid),
    .pop       (pop),
    .flush     (flush),
    .push_data (in_entry),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  assign seq_pc       = res_pc + XLEN'(4);
  assign nxt_redirect = (res_taken & res_is_branch) ? res_target : seq_pc;

  always_comb begin
    nxt_update = 1'b0;
    nxt_mis    = 1'b0;
    nxt_fsm    = STRONG_NT;
    nxt_target = res_target;
    if (res_is_branch) begin
      nxt_mis = (head.taken != res_taken) | (res_taken & (head_target != res_target));
      if (head.hit) begin
        nxt_update = 1'b1;
        nxt_fsm    = fsm_step(head.fsm, res_taken);
      end else if (res_taken) begin
        nxt_update = 1'b1;
        nxt_fsm    = WEAK_T;
      end
    end else if (head.hit & head.taken) begin
      // A taken hit on a non-branch is an alias: kill it by pointing at the fall-through.
      nxt_mis    = 1'b1;
      nxt_update = 1'b1;
      nxt_fsm    = STRONG_NT;
      nxt_target = seq_pc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      update       <= 1'b0;
      mispredicted <= 1'b0;
      updatePC     <= '0;
      updateTarget <= '0;
      update_fsm   <= '0;
      redirect_pc  <= '0;
      desync       <= 1'b0;
    end else begin
      update       <= pop & nxt_update;
      mispredicted <= pop & nxt_mis;
      if (pop) begin
        updatePC     <= res_pc;
        updateTarget <= nxt_target;
        update_fsm   <= nxt_fsm;
        redirect_pc  <= nxt_redirect;
        if (head_pc != res_pc) desync <= 1'b1;
      end
    end
  end

`ifdef BTB_RESOLVE_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (pop & res_is_branch & ~&stat_branches) stat_branches <= stat_branches + 32'd1;
      if (pop & nxt_mis & ~&stat_mispredicts)    stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: doc/btb_resolve_unit.md
Name: btb_resolve_unit

Overview:
- Execute-side companion to the IF-stage BTB lookup.
- Buffers each fetch-time prediction (hit, target, taken, 2-bit FSM state) in order. When the branch resolves in EX, it compares the prediction with the actual outcome.
- Produces the BTB write-back (update, updatePC, updateTarget, new FSM state), the mispredicted flag and the fetch redirect PC.
- Flushes all younger buffered predictions on a mispredict.

Parameters:
- DEPTH, 4, number of in-flight predictions buffered (power of 2, ≥2)
- XLEN, 32, PC/target width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- fetch_valid  in  1  push fetch-time prediction
- fetch_pc  in  XLEN  PC looked up in BTB
- pred_hit  in  1  BTB valid
- pred_target  in  XLEN  BTB target
- pred_taken  in  1  BTB predictedTaken
- pred_fsm  in  2  BTB FSM state of hit entry (don't-care on miss)
- fetch_ready  out  1  buffer not full
- res_valid  in  1  EX resolution for oldest instruction
- res_pc  in  XLEN  resolved instruction PC
- res_is_branch  in  1  instruction is a branch/jump
- res_taken  in  1  actual direction
- res_target  in  XLEN  actual target
- res_ready  out  1  buffer not empty
- update  out  1  BTB write enable (one-cycle pulse)
- updatePC  out  XLEN  BTB write PC
- updateTarget  out  XLEN  BTB write target
- update_fsm  out  2  FSM state to write
- mispredicted  out  1  one-cycle pulse
- redirect_pc  out  XLEN  correct next fetch PC
- desync  out  1  sticky: res_pc ≠ head fetch_pc

Behaviour:
- Reset (async, any time): buffer empty, all outputs 0. fetch_ready=1, res_ready=0.
- Push accepted when fetch_valid & fetch_ready; the entry is stored at the tail. fetch_ready = !full. A pop in the same cycle does not raise fetch_ready.
- Pop occurs when res_valid & res_ready. The outcome is evaluated against the head entry combinationally; all result outputs are registered, so latency is 1 cycle after the pop cycle.
- res_valid while empty: ignored, no outputs, no state change.
- Mispredict, evaluated on the popped entry:
  - Branch: pred_taken≠res_taken, or res_taken & pred_target≠res_target.
  - Non-branch: pred_hit & pred_taken (alias).
- redirect_pc = res_taken&res_is_branch ? res_target : res_pc+4. Addition is mod 2^XLEN; 0xFFFFFFFC wraps to 0.
- FSM update (saturating): STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11.
  - Hit & taken → +1, saturating at 11.
  - Hit & not-taken → −1, saturating at 00.
  - Miss & taken → allocate at WEAK_T.
  - Miss & not-taken → no update.
  - Non-branch alias hit → update with fsm=00 and updateTarget=res_pc+4.
- update, updatePC=res_pc and updateTarget=res_target are driven for every branch except a not-taken miss.
- Flush: on a mispredicted pop, the buffer is emptied at the end of the pop cycle. A push in that same cycle is dropped.
- desync is set when a popped head PC ≠ res_pc. It stays set until reset. Evaluation proceeds normally.
- Pointer wrap: DEPTH-power-of-2 counters with an extra MSB distinguish full from empty.

Optional Feature:
- Macro: BTB_RESOLVE_STATS_EN.
- With the macro: 32-bit outputs stat_branches and stat_mispredicts are added.
  - They increment on each resolved branch and each mispredict, respectively (alias mispredicts included).
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Without the macro: the ports and counters are absent.

Decomposition:
- Package btb_pkg holds:
  - enum btb_fsm_t (4 states above)
  - struct pred_entry_t {pc, hit, target, taken, fsm}
  - constant BTB_INDEX_BITS=3
  - constant BTB_TAG_BITS=27
- Sub-module pred_fifo holds the synchronous FIFO of pred_entry_t, with push, pop, flush, full and empty.
- btb_resolve_unit contains the evaluation, FSM arithmetic and output registers.

Test Plan:
- Reset mid-stream with 3 entries buffered → next cycle fetch_ready=1, res_ready=0, update=0, desync=0.
- Push pc=0x100, hit=1, taken=1, fsm=10, target=0x200; resolve taken to 0x200 → one cycle later update=1, update_fsm=11, mispredicted=0.
- Push pc=0x100, hit=1, fsm=11, taken=1; resolve not-taken → mispredicted=1, redirect_pc=0x104, update_fsm=10. Buffer empties; a concurrent push of 0x104 is dropped.
- Push pc=0x40, miss; resolve taken to 0x80 → update=1, updatePC=0x40, updateTarget=0x80, update_fsm=10, mispredicted=1, redirect_pc=0x80. Then a miss resolved not-taken → update=0, mispredicted=0.
- Fill to DEPTH=4 → fetch_ready=0 and the 5th push is ignored. Drain 4 correct predictions with wrap-around → res_ready=0 and FIFO order preserved.
- Resolve with res_pc=0x108 against head 0x104 → desync=1, still set after 10 further cycles. Non-branch alias hit with taken=1 → mispredicted=1, redirect_pc=0x108, update_fsm=00.
